reg_dump_tx: RTL

//  Debug reader at the far end of the register file read port: on a start request it walks a

---
 rtl/regdbg_pkg.sv | 20 ++
 rtl/reg_dump_tx_bit_timer.sv | 28 ++
 rtl/reg_dump_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regdbg_pkg.sv
// Shared types for the register-dump serial reader: FSM state encoding and frame geometry.
package regdbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START_BIT,
    DATA,
    STOP_BIT,
    FINISH
  } dump_state_t;

  // One start bit plus one stop bit around the data word.
  localparam int FRAME_OVERHEAD = 2;

  function automatic int frame_bits(input int data_bits);
    return data_bits + FRAME_OVERHEAD;
  endfunction

endpackage

// File: rtl/reg_dump_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic nReset,
  input  logic clr_i,
  output logic bit_tick_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST_CNT)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!nReset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign bit_tick_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/reg_dump_tx.sv
// Walks a register address range on the spare read port and sends each word as a UART frame.
module reg_dump_tx
  import regdbg_pkg::*;
#(
  parameter int n            = 8,
  parameter int AW           = 3,
  parameter int FIRST_ADDR   = 1,
  parameter int LAST_ADDR    = 7,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] Raddr,
  input  logic [n-1:0]  Rdata,
  output logic          tx,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] FIRST_A  = AW'(FIRST_ADDR);
  localparam logic [AW-1:0] LAST_A   = AW'(LAST_ADDR);
  localparam int            BW       = (n > 2) ? $clog2(n) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(n - 1);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [n-1:0]  shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          tx_q, tx_d;
  logic          tick;
  logic          timer_clr;

  // Restart the bit period on every state change so each phase starts on a full bit.
  assign timer_clr = (state_d != state_q) || (state_q == IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk        (clk),
    .nReset     (nReset),
    .clr_i      (timer_clr),
    .bit_tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        addr_d  = FIRST_A;
      end
      LOAD: begin
        shift_d = Rdata;
        state_d = START_BIT;
      end
      START_BIT: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_q == LAST_BIT) begin
          state_d = STOP_BIT;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      STOP_BIT: if (tick) begin
        if (addr_q == LAST_A) begin
          state_d = FINISH;
        end else begin
          addr_d  = addr_q + AW'(1);
          state_d = LOAD;
        end
      end
      FINISH: begin
        state_d = IDLE;
        addr_d  = FIRST_A;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including a start arriving in the same cycle.
    if (abort) begin
      state_d = IDLE;
      addr_d  = FIRST_A;
      bit_d   = '0;
    end
    // tx is registered from the next state so the line changes on the phase boundary.
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = shift_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= IDLE;
      addr_q  <= FIRST_A;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign Raddr = addr_q;
  assign tx    = tx_q;
  assign busy  = (state_q == LOAD) || (state_q == START_BIT) ||
                 (state_q == DATA) || (state_q == STOP_BIT);
  assign done  = (state_q == FINISH);

endmodule
